// File: rtl/ysyx_23060303_wbu.sv
// Writeback unit: formats load data, buffers up to two completed results, drives the
// register-file write port, and tracks per-register pending writes with forwarding.
module ysyx_23060303_wbu #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  iss_valid,
  input  logic [ADDR_WIDTH-1:0] iss_rd,
  output logic                  iss_ready,
  input  logic [ADDR_WIDTH-1:0] chk_rs1,
  input  logic [ADDR_WIDTH-1:0] chk_rs2,
  output logic                  rs1_busy,
  output logic                  rs2_busy,
  output logic                  fwd_rs1_hit,
  output logic                  fwd_rs2_hit,
  output logic [DATA_WIDTH-1:0] fwd_rs1_data,
  output logic [DATA_WIDTH-1:0] fwd_rs2_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_WIDTH-1:0] in_rd,
  input  logic [DATA_WIDTH-1:0] in_result,
  input  logic                  in_is_load,
  input  logic [2:0]            in_ld_funct3,
  input  logic [1:0]            in_ld_addr_lo,
  input  logic [DATA_WIDTH-1:0] in_rdata,
  input  logic                  rf_gnt,
  output logic                  wen,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [DATA_WIDTH-1:0] wdata
);

  localparam int NREG = 1 << ADDR_WIDTH;

  // Aligns the addressed byte/half to bit 0, then sign- or zero-extends by load type.
  function automatic logic [DATA_WIDTH-1:0] fmt_load(
    input logic [2:0]            funct3,
    input logic [1:0]            lo,
    input logic [DATA_WIDTH-1:0] raw
  );
    logic [DATA_WIDTH-1:0] sh;
    sh = raw >> {lo, 3'b000};
    case (funct3)
      3'b000:  fmt_load = {{(DATA_WIDTH-8){sh[7]}}, sh[7:0]};
      3'b001:  fmt_load = {{(DATA_WIDTH-16){sh[15]}}, sh[15:0]};
      3'b010:  fmt_load = sh;
      3'b100:  fmt_load = {{(DATA_WIDTH-8){1'b0}}, sh[7:0]};
      3'b101:  fmt_load = {{(DATA_WIDTH-16){1'b0}}, sh[15:0]};
      default: fmt_load = raw;
    endcase
  endfunction

  // Two-entry FIFO: head_r points at the oldest entry, cnt_r is occupancy.
  logic [ADDR_WIDTH-1:0] ent_rd_r   [2];
  logic [DATA_WIDTH-1:0] ent_data_r [2];
  logic                  head_r;
  logic [1:0]            cnt_r;
  logic [1:0]            pend_r     [NREG];

  logic                  head_valid_s;
  logic                  wr_idx_s;
  logic                  enq_s;
  logic                  pop_s;
  logic                  iss_inc_s;
  logic [DATA_WIDTH-1:0] in_data_s;

  // Handshake, enqueue/pop qualifiers and formatted write data.
  always_comb begin
    head_valid_s = (cnt_r != 2'd0);
    in_ready     = (cnt_r != 2'd2);
    wr_idx_s     = head_r ^ cnt_r[0];
    enq_s        = in_valid & in_ready & (in_rd != {ADDR_WIDTH{1'b0}});
    pop_s        = head_valid_s & rf_gnt;
    iss_inc_s    = iss_valid & iss_ready & (iss_rd != {ADDR_WIDTH{1'b0}});
    if (in_is_load) begin
      in_data_s = fmt_load(in_ld_funct3, in_ld_addr_lo, in_rdata);
    end else begin
      in_data_s = in_result;
    end
  end

  // Write port is driven only from buffered state and the grant.
  always_comb begin
    wen = pop_s;
    if (head_valid_s) begin
      waddr = ent_rd_r[head_r];
      wdata = ent_data_r[head_r];
    end else begin
      waddr = {ADDR_WIDTH{1'b0}};
      wdata = {DATA_WIDTH{1'b0}};
    end
  end

  // FIFO storage, head pointer and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        ent_rd_r[i]   <= {ADDR_WIDTH{1'b0}};
        ent_data_r[i] <= {DATA_WIDTH{1'b0}};
      end
      head_r <= 1'b0;
      cnt_r  <= 2'd0;
    end else begin
      if (enq_s) begin
        ent_rd_r[wr_idx_s]   <= in_rd;
        ent_data_r[wr_idx_s] <= in_data_s;
      end
      if (pop_s) begin
        head_r <= ~head_r;
      end
      case ({enq_s, pop_s})
        2'b10:   cnt_r <= cnt_r + 2'd1;
        2'b01:   cnt_r <= cnt_r - 2'd1;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Pending-write scoreboard; x0 never counts, decrement saturates at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        pend_r[i] <= 2'd0;
      end
    end else begin
      pend_r[0] <= 2'd0;
      for (int i = 1; i < NREG; i++) begin
        if (iss_inc_s && (iss_rd == i[ADDR_WIDTH-1:0]) &&
            !(pop_s && (waddr == i[ADDR_WIDTH-1:0]))) begin
          pend_r[i] <= pend_r[i] + 2'd1;
        end else if (pop_s && (waddr == i[ADDR_WIDTH-1:0]) &&
                     !(iss_inc_s && (iss_rd == i[ADDR_WIDTH-1:0])) &&
                     (pend_r[i] != 2'd0)) begin
          pend_r[i] <= pend_r[i] - 2'd1;
        end else begin
          pend_r[i] <= pend_r[i];
        end
      end
    end
  end

  // Looks up a source index in the buffer; the younger (tail) entry wins.
  function automatic logic [DATA_WIDTH:0] fwd_lookup(
    input logic [ADDR_WIDTH-1:0] rs,
    input logic [1:0]            cnt,
    input logic [ADDR_WIDTH-1:0] rd_old,
    input logic [DATA_WIDTH-1:0] d_old,
    input logic [ADDR_WIDTH-1:0] rd_young,
    input logic [DATA_WIDTH-1:0] d_young
  );
    if (rs == {ADDR_WIDTH{1'b0}}) begin
      fwd_lookup = {1'b0, {DATA_WIDTH{1'b0}}};
    end else if ((cnt == 2'd2) && (rd_young == rs)) begin
      fwd_lookup = {1'b1, d_young};
    end else if ((cnt != 2'd0) && (rd_old == rs)) begin
      fwd_lookup = {1'b1, d_old};
    end else begin
      fwd_lookup = {1'b0, {DATA_WIDTH{1'b0}}};
    end
  endfunction

  // Operand forwarding, busy flags and issue back-pressure.
  always_comb begin
    {fwd_rs1_hit, fwd_rs1_data} = fwd_lookup(chk_rs1, cnt_r,
                                             ent_rd_r[head_r], ent_data_r[head_r],
                                             ent_rd_r[~head_r], ent_data_r[~head_r]);
    {fwd_rs2_hit, fwd_rs2_data} = fwd_lookup(chk_rs2, cnt_r,
                                             ent_rd_r[head_r], ent_data_r[head_r],
                                             ent_rd_r[~head_r], ent_data_r[~head_r]);
    rs1_busy  = (pend_r[chk_rs1] != 2'd0) & ~fwd_rs1_hit;
    rs2_busy  = (pend_r[chk_rs2] != 2'd0) & ~fwd_rs2_hit;
    iss_ready = (iss_rd == {ADDR_WIDTH{1'b0}}) | (pend_r[iss_rd] != 2'd3);
  end

endmodule

// File: tb/tb_ysyx_23060303_wbu.sv
// Directed self-checking bench for ysyx_23060303_wbu: inputs change on the falling
// edge and outputs are checked 1ns later, well away from the rising edge.
module tb_ysyx_23060303_wbu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        iss_ready;
  logic [4:0]  chk_rs1, chk_rs2;
  logic        rs1_busy, rs2_busy, fwd_rs1_hit, fwd_rs2_hit;
  logic [31:0] fwd_rs1_data, fwd_rs2_data;
  logic        in_valid, in_ready;
  logic [4:0]  in_rd;
  logic [31:0] in_result;
  logic        in_is_load;
  logic [2:0]  in_ld_funct3;
  logic [1:0]  in_ld_addr_lo;
  logic [31:0] in_rdata;
  logic        rf_gnt, wen;
  logic [4:0]  waddr;
  logic [31:0] wdata;

  int checks = 0;
  int errors = 0;

  ysyx_23060303_wbu #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .chk_rs1(chk_rs1), .chk_rs2(chk_rs2),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .fwd_rs1_hit(fwd_rs1_hit), .fwd_rs2_hit(fwd_rs2_hit),
    .fwd_rs1_data(fwd_rs1_data), .fwd_rs2_data(fwd_rs2_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_result(in_result),
    .in_is_load(in_is_load), .in_ld_funct3(in_ld_funct3), .in_ld_addr_lo(in_ld_addr_lo),
    .in_rdata(in_rdata), .rf_gnt(rf_gnt),
    .wen(wen), .waddr(waddr), .wdata(wdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [2:0] f3, input logic [1:0] lo, input logic [31:0] exp,
                         input string tag);
    @(negedge clk);
    in_valid = 1'b1; in_rd = 5'd1; in_is_load = 1'b1;
    in_ld_funct3 = f3; in_ld_addr_lo = lo; in_rdata = 32'h80FF_7F01;
    @(negedge clk);
    in_valid = 1'b0; in_is_load = 1'b0;
    #1;
    chk({tag, "_wen"}, {31'd0, wen}, 32'd1);
    chk(tag, wdata, exp);
  endtask

  initial begin
    rst_n = 1'b0; iss_valid = 1'b0; iss_rd = 5'd0; chk_rs1 = 5'd0; chk_rs2 = 5'd0;
    in_valid = 1'b0; in_rd = 5'd0; in_result = 32'd0; in_is_load = 1'b0;
    in_ld_funct3 = 3'd0; in_ld_addr_lo = 2'd0; in_rdata = 32'd0; rf_gnt = 1'b0;

    // reset values
    @(negedge clk); #1;
    chk("rst_wen", {31'd0, wen}, 32'd0);
    chk("rst_waddr", {27'd0, waddr}, 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_iss_ready", {31'd0, iss_ready}, 32'd1);
    chk("rst_busy", {30'd0, rs1_busy, rs2_busy}, 32'd0);
    chk("rst_hit", {30'd0, fwd_rs1_hit, fwd_rs2_hit}, 32'd0);
    chk("rst_fwd", fwd_rs1_data | fwd_rs2_data, 32'd0);
    rst_n = 1'b1;

    // single ALU result to x5
    @(negedge clk);
    iss_valid = 1'b1; iss_rd = 5'd5;
    #1 chk("t1_iss_ready", {31'd0, iss_ready}, 32'd1);
    @(negedge clk);
    iss_valid = 1'b0; chk_rs1 = 5'd5;
    in_valid = 1'b1; in_rd = 5'd5; in_result = 32'h1234_5678; rf_gnt = 1'b1;
    #1;
    chk("t1_busy_before", {31'd0, rs1_busy}, 32'd1);
    chk("t1_in_ready", {31'd0, in_ready}, 32'd1);
    chk("t1_no_comb_wen", {31'd0, wen}, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("t1_wen", {31'd0, wen}, 32'd1);
    chk("t1_waddr", {27'd0, waddr}, 32'd5);
    chk("t1_wdata", wdata, 32'h1234_5678);
    chk("t1_hit", {31'd0, fwd_rs1_hit}, 32'd1);
    chk("t1_fwd", fwd_rs1_data, 32'h1234_5678);
    chk("t1_busy_hit", {31'd0, rs1_busy}, 32'd0);
    @(negedge clk); #1;
    chk("t1_wen_off", {31'd0, wen}, 32'd0);
    chk("t1_busy_after", {31'd0, rs1_busy}, 32'd0);
    chk("t1_hit_after", {31'd0, fwd_rs1_hit}, 32'd0);

    // load formatting on in_rdata = 0x80FF7F01
    do_load(3'b000, 2'd3, 32'hFFFF_FF80, "lb3");
    do_load(3'b100, 2'd3, 32'h0000_0080, "lbu3");
    do_load(3'b001, 2'd2, 32'hFFFF_80FF, "lh2");
    do_load(3'b101, 2'd0, 32'h0000_7F01, "lhu0");
    do_load(3'b010, 2'd0, 32'h80FF_7F01, "lw0");
    do_load(3'b000, 2'd1, 32'h0000_007F, "lb1");
    do_load(3'b011, 2'd1, 32'h80FF_7F01, "f3_011_raw");

    // back-pressure with the grant low, then in-order drain
    @(negedge clk);
    rf_gnt = 1'b0; in_valid = 1'b1; in_rd = 5'd10; in_result = 32'hA0;
    @(negedge clk);
    in_rd = 5'd11; in_result = 32'hB0;
    #1 chk("t3_ready_one", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_rd = 5'd12; in_result = 32'hC0;
    #1;
    chk("t3_full", {31'd0, in_ready}, 32'd0);
    chk("t3_no_wen", {31'd0, wen}, 32'd0);
    @(negedge clk);
    rf_gnt = 1'b1;
    #1;
    chk("t3_held_ready", {31'd0, in_ready}, 32'd0);
    chk("t3_wen0", {31'd0, wen}, 32'd1);
    chk("t3_waddr0", {27'd0, waddr}, 32'd10);
    chk("t3_wdata0", wdata, 32'hA0);
    @(negedge clk); #1;
    chk("t3_ready_pop", {31'd0, in_ready}, 32'd1);
    chk("t3_waddr1", {27'd0, waddr}, 32'd11);
    chk("t3_wdata1", wdata, 32'hB0);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("t3_wen2", {31'd0, wen}, 32'd1);
    chk("t3_waddr2", {27'd0, waddr}, 32'd12);
    chk("t3_wdata2", wdata, 32'hC0);
    @(negedge clk); #1;
    chk("t3_empty", {31'd0, wen}, 32'd0);

    // two buffered writes to x7, youngest forwards
    rf_gnt = 1'b0; iss_valid = 1'b1; iss_rd = 5'd7;
    @(negedge clk);
    @(negedge clk);
    iss_valid = 1'b0; chk_rs1 = 5'd7;
    in_valid = 1'b1; in_rd = 5'd7; in_result = 32'hA;
    #1;
    chk("t4_busy", {31'd0, rs1_busy}, 32'd1);
    chk("t4_nohit", {31'd0, fwd_rs1_hit}, 32'd0);
    @(negedge clk);
    in_result = 32'hB;
    #1 chk("t4_fwd_a", fwd_rs1_data, 32'hA);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("t4_fwd_young", fwd_rs1_data, 32'hB);
    chk("t4_busy_hit", {31'd0, rs1_busy}, 32'd0);
    rf_gnt = 1'b1;
    @(negedge clk); #1;
    chk("t4_hit_after1", {31'd0, fwd_rs1_hit}, 32'd1);
    chk("t4_fwd_after1", fwd_rs1_data, 32'hB);
    chk("t4_wdata", wdata, 32'hB);
    @(negedge clk); #1;
    chk("t4_hit_done", {31'd0, fwd_rs1_hit}, 32'd0);
    chk("t4_busy_done", {31'd0, rs1_busy}, 32'd0);

    // scoreboard saturation and same-cycle issue/write on x3
    rf_gnt = 1'b0; iss_valid = 1'b1; iss_rd = 5'd3;
    #1 chk("t5_ready0", {31'd0, iss_ready}, 32'd1);
    @(negedge clk);
    @(negedge clk); #1;
    chk("t5_ready2", {31'd0, iss_ready}, 32'd1);
    @(negedge clk); #1;
    chk("t5_ready3", {31'd0, iss_ready}, 32'd0);
    iss_valid = 1'b0; in_valid = 1'b1; in_rd = 5'd3; in_result = 32'h31;
    @(negedge clk);
    in_result = 32'h32;
    @(negedge clk);
    in_valid = 1'b0; rf_gnt = 1'b1;
    #1;
    chk("t5_waddr", {27'd0, waddr}, 32'd3);
    chk("t5_wdata0", wdata, 32'h31);
    @(negedge clk);
    iss_valid = 1'b1; iss_rd = 5'd3;
    #1;
    chk("t5_ready_at2", {31'd0, iss_ready}, 32'd1);
    chk("t5_wen_same", {31'd0, wen}, 32'd1);
    chk("t5_wdata1", wdata, 32'h32);
    @(negedge clk);
    iss_valid = 1'b0; chk_rs2 = 5'd3;
    #1;
    chk("t5_busy2", {31'd0, rs2_busy}, 32'd1);
    chk("t5_nohit", {31'd0, fwd_rs2_hit}, 32'd0);
    chk("t5_ready_still", {31'd0, iss_ready}, 32'd1);
    iss_valid = 1'b1;
    @(negedge clk);
    iss_valid = 1'b0;
    #1 chk("t5_ready_full", {31'd0, iss_ready}, 32'd0);

    // destination x0: handshake only
    in_valid = 1'b1; in_rd = 5'd0; in_result = 32'hDEAD; iss_valid = 1'b1; iss_rd = 5'd0;
    chk_rs1 = 5'd0;
    #1;
    chk("t5_x0_iss_ready", {31'd0, iss_ready}, 32'd1);
    chk("t5_x0_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0; iss_valid = 1'b0;
    #1;
    chk("t5_x0_wen", {31'd0, wen}, 32'd0);
    chk("t5_x0_busy", {31'd0, rs1_busy}, 32'd0);
    chk("t5_x0_hit", {31'd0, fwd_rs1_hit}, 32'd0);

    // reset with two entries buffered
    rf_gnt = 1'b0; in_valid = 1'b1; in_rd = 5'd20; in_result = 32'h20;
    @(negedge clk);
    in_rd = 5'd21; in_result = 32'h21;
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("t6_full", {31'd0, in_ready}, 32'd0);
    rf_gnt = 1'b1;
    #1;
    chk("t6_wen_pre", {31'd0, wen}, 32'd1);
    chk("t6_waddr_pre", {27'd0, waddr}, 32'd20);
    rst_n = 1'b0;
    #1 chk("t6_wen_async", {31'd0, wen}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; chk_rs2 = 5'd3; iss_rd = 5'd3;
    #1;
    chk("t6_in_ready", {31'd0, in_ready}, 32'd1);
    chk("t6_busy", {30'd0, rs1_busy, rs2_busy}, 32'd0);
    chk("t6_iss_ready", {31'd0, iss_ready}, 32'd1);
    chk("t6_waddr", {27'd0, waddr}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("t6_no_write", {31'd0, wen}, 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
